// File: rtl/pwm_multi_ch_pkg.sv
// Shared constants for the multi-channel PWM: register map, CTRL bit
// positions and the run-control FSM state encoding.
package pwm_multi_ch_pkg;

  // Register map
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PERIOD   = 1;
  localparam int ADDR_PRESCALE = 2;
  localparam int ADDR_POL      = 3;
  localparam int ADDR_DUTY0    = 4;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CENTER  = 1;
  localparam int CTRL_EXT_SEL = 2;
  localparam int CTRL_W       = 3;

  // Run-control FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: holds the active (shadow-loaded) duty value, compares it
// against the shared counter and registers the raw (pre-polarity) output.
module pwm_cmp_ch
  import pwm_multi_ch_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_duty_nxt,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_en,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;
  logic             w_cmp;

  // Unsigned compare: duty 0 never high, duty above the counter range always high
  assign w_cmp = (i_cnt < r_duty_act);

  // Active duty only changes on a start or period boundary load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_act <= '0;
    end else if (i_load) begin
      r_duty_act <= i_duty_nxt;
    end
  end

  // Output flop trails the counter by one clock; forced low when not running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en & w_cmp;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator behind a simple register port.
// Edge- or centre-aligned counting, prescaler, double-buffered PERIOD/DUTY/
// CENTER, optional external start trigger through a 2-flop synchroniser.
// Build option: define PWM_POLARITY_EN to add the per-channel POL invert
// mask at address 3 (otherwise address 3 is unmapped).
//
// Register port: reg_we and reg_re are single-cycle strobes with no ready;
// every write is accepted on the edge it is sampled, and a read strobe
// updates reg_rdata on the next edge, which then holds until the next read.
module pwm_multi_ch
  import pwm_multi_ch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [CNT_W-1:0]  reg_wdata,
  output logic [CNT_W-1:0]  reg_rdata,
  input  logic              start_ext,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Register file
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_period_stg;
  logic [CNT_W-1:0]  r_prescale;
  logic [CNT_W-1:0]  r_duty_stg [NUM_CH];
  logic [CNT_W-1:0]  r_rdata;

  // Active (shadowed) timing configuration
  logic [CNT_W-1:0]  r_period_act;
  logic              r_center_act;

  // Counter state
  logic [CNT_W-1:0]  r_psc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dir;      // 0 = counting up, 1 = counting down
  logic              r_tick;

  // Start synchroniser
  logic [1:0]        r_sync;
  logic              r_sync_q;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_ctrl_wr;
  logic              w_period_wr;
  logic              w_prescale_wr;
  logic              w_en_wr1;
  logic              w_stop;
  logic              w_ext_edge;
  logic              w_run;
  logic              w_start;
  logic              w_adv;
  logic              w_boundary;
  logic              w_load;
  logic              w_pwm_en;
  logic [CNT_W-1:0]  w_period_nxt;
  logic              w_center_nxt;
  logic [CNT_W-1:0]  w_duty_nxt [NUM_CH];
  logic [CNT_W-1:0]  w_rd;
  logic [NUM_CH-1:0] w_raw;

  assign w_ctrl_wr     = reg_we && (int'(reg_addr) == ADDR_CTRL);
  assign w_period_wr   = reg_we && (int'(reg_addr) == ADDR_PERIOD);
  assign w_prescale_wr = reg_we && (int'(reg_addr) == ADDR_PRESCALE);
  assign w_en_wr1      = w_ctrl_wr &&  reg_wdata[CTRL_EN];
  assign w_stop        = w_ctrl_wr && !reg_wdata[CTRL_EN];

  // Staged values as they will be after this edge, so a write that lands on
  // a load edge is the one that gets loaded
  always_comb begin
    w_period_nxt = w_period_wr ? reg_wdata : r_period_stg;
    w_center_nxt = w_ctrl_wr ? reg_wdata[CTRL_CENTER] : r_ctrl[CTRL_CENTER];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_duty_nxt[ch] = (reg_we && (int'(reg_addr) == ADDR_DUTY0 + ch)) ?
                       reg_wdata : r_duty_stg[ch];
    end
  end

  // Control, staging and prescale registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl       <= '0;
      r_period_stg <= '0;
      r_prescale   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) r_duty_stg[ch] <= '0;
    end else begin
      if (w_ctrl_wr)     r_ctrl     <= reg_wdata[CTRL_W-1:0];
      if (w_prescale_wr) r_prescale <= reg_wdata;
      r_period_stg <= w_period_nxt;
      r_duty_stg   <= w_duty_nxt;
    end
  end

`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] r_pol;
  logic [CNT_W-1:0]  w_pol_rd;
  logic              w_pol_wr;

  assign w_pol_wr = reg_we && (int'(reg_addr) == ADDR_POL);

  // Invert mask applies immediately, not shadowed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pol <= '0;
    end else if (w_pol_wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i < CNT_W) r_pol[i] <= reg_wdata[i % CNT_W];
      end
    end
  end

  // Mask zero-extended (or truncated) to the data width for readback
  always_comb begin
    w_pol_rd = '0;
    for (int j = 0; j < CNT_W; j++) begin
      if (j < NUM_CH) w_pol_rd[j] = r_pol[j % NUM_CH];
    end
  end

  assign pwm_out = w_raw ^ r_pol;
`else
  assign pwm_out = w_raw;
`endif

  // Read mux; PERIOD/DUTY return the staged values
  always_comb begin
    w_rd = '0;
    if (int'(reg_addr) == ADDR_CTRL)          w_rd = CNT_W'(r_ctrl);
    else if (int'(reg_addr) == ADDR_PERIOD)   w_rd = r_period_stg;
    else if (int'(reg_addr) == ADDR_PRESCALE) w_rd = r_prescale;
`ifdef PWM_POLARITY_EN
    else if (int'(reg_addr) == ADDR_POL)      w_rd = w_pol_rd;
`endif
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (int'(reg_addr) == ADDR_DUTY0 + ch) w_rd = r_duty_stg[ch];
    end
  end

  // Registered read data, held between read strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (reg_re) begin
      r_rdata <= w_rd;
    end
  end

  assign reg_rdata = r_rdata;

  // External start: two-flop synchroniser plus rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], start_ext};
      r_sync_q <= r_sync[1];
    end
  end

  assign w_ext_edge = r_sync[1] & ~r_sync_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: EN=0 always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_en_wr1) w_state_nxt = reg_wdata[CTRL_EXT_SEL] ? ARMED : RUN;
      end
      ARMED: begin
        if (w_stop)          w_state_nxt = IDLE;
        else if (w_ext_edge) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_stop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: run flag and the start event that triggers the first load
  always_comb begin
    w_run   = (r_state == RUN);
    w_start = ((r_state == IDLE) && w_en_wr1 && !reg_wdata[CTRL_EXT_SEL]) ||
              ((r_state == ARMED) && !w_stop && w_ext_edge);
  end

  assign busy      = w_run;
  assign dbg_state = r_state;

  // Advance enable and period boundary
  assign w_adv      = w_run && (r_psc >= r_prescale);
  assign w_boundary = w_adv && !w_stop &&
                      (r_center_act ? (r_dir && (r_cnt == '0))
                                    : (r_cnt >= r_period_act));
  assign w_load     = w_start | w_boundary;
  assign w_pwm_en   = w_run & ~w_stop;

  // Prescaler and up / up-down counter
  always_ff @(posedge clk) begin
    if (rst || !w_run || w_stop) begin
      r_psc <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (w_adv) begin
      r_psc <= '0;
      if (w_boundary) begin
        // A centre period continuing in centre mode resumes at 1 (0 was the
        // boundary slot); every other case restarts from 0 counting up
        r_dir <= 1'b0;
        r_cnt <= (r_center_act && w_center_nxt && (w_period_nxt != '0)) ?
                 CNT_W'(1) : '0;
      end else if (!r_center_act) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!r_dir) begin
        if (r_cnt >= r_period_act) begin
          r_dir <= 1'b1;
          r_cnt <= (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else begin
      r_psc <= r_psc + CNT_W'(1);
    end
  end

  // Shadow load of period and mode at start and at each boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_act <= '0;
      r_center_act <= 1'b0;
    end else if (w_load) begin
      r_period_act <= w_period_nxt;
      r_center_act <= w_center_nxt;
    end
  end

  // Period tick: one clock, aligned with the newly loaded values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_boundary;
    end
  end

  assign period_tick = r_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_cmp_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_duty_nxt (w_duty_nxt[g]),
      .i_cnt      (r_cnt),
      .i_en       (w_pwm_en),
      .o_pwm      (w_raw[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: register map and reset values, edge and
// centre patterns, duty shadowing, external start and stop/reset behaviour.
module tb_pwm_multi_ch;
  import pwm_multi_ch_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;
  localparam int W      = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reg_we = 1'b0;
  logic              reg_re = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [CNT_W-1:0]  reg_wdata = '0;
  logic [CNT_W-1:0]  reg_rdata;
  logic              start_ext = 1'b0;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_tick;
  logic              busy;
  logic [1:0]        dbg_state;

  logic [W-1:0] exp_q[$];   // expected {period_tick, pwm_out} per cycle
  logic [W-1:0] rd_q[$];    // expected read data
  int n_checks = 0;
  int n_errors = 0;
  logic [NUM_CH-1:0] pol_mask = '0;

  pwm_multi_ch #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .start_ext  (start_ext),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic wr(input int a, input int d);
    reg_we    = 1'b1;
    reg_addr  = ADDR_W'(a);
    reg_wdata = CNT_W'(d);
    step();
    reg_we    = 1'b0;
  endtask

  task automatic rd(input int a, input int want, input string tag);
    rd_q.push_back(W'(want));
    reg_re   = 1'b1;
    reg_addr = ADDR_W'(a);
    step();
    reg_re   = 1'b0;
    check(tag, W'(reg_rdata), rd_q.pop_front());
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Edge mode, PERIOD=9, DUTY={0,10,0,d0}; k=0 is the tick cycle, and the
  // output at k reflects the counter value of cycle k-1
  function automatic logic [W-1:0] edge_exp(input int k, input int d0, input logic [NUM_CH-1:0] pol);
    int cp;
    logic [NUM_CH-1:0] p;
    cp   = (k + 9) % 10;
    p    = '0;
    p[0] = (cp < d0);
    p[2] = 1'b1;
    return W'({((k % 10) == 0), p ^ pol});
  endfunction

  // Centre mode, PERIOD=4, PRESCALE=1, DUTY0=2: counter sequence after the
  // boundary is 1,2,3,4,3,2,1,0 with each value held two clocks
  function automatic logic [W-1:0] centre_exp(input int k, input logic [NUM_CH-1:0] pol);
    int kk, m, c;
    logic [NUM_CH-1:0] p;
    kk   = (k + 15) % 16;
    m    = (kk / 2) % 8;
    c    = (m < 4) ? (m + 1) : (7 - m);
    p    = '0;
    p[0] = (c < 2);
    p[2] = 1'b1;
    return W'({((k % 16) == 0), p ^ pol});
  endfunction

  initial begin
    int n;
    bit ok;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    check("rst_outs", W'({period_tick, busy, pwm_out}), '0);
    rst = 1'b0;
    step();
    check("idle_pwm", W'(pwm_out), '0);
    check("idle_busy", W'(busy), '0);
    check("idle_state", W'(dbg_state), W'(IDLE));
    for (int a = 0; a < 16; a++) rd(a, 0, $sformatf("rst_rd%0d", a));

    // Register map boundaries
    wr(ADDR_CTRL, 'hF8);
    rd(ADDR_CTRL, 0, "ctrl_upper_bits");
    wr(ADDR_CTRL, 6);
    rd(ADDR_CTRL, 6, "ctrl_bits");
    check("ctrl_no_en_state", W'(dbg_state), W'(IDLE));
    wr(ADDR_CTRL, 0);
    wr(8, 'h55);
    rd(8, 0, "unmapped8");
`ifdef PWM_POLARITY_EN
    wr(ADDR_POL, 'hF1);
    rd(ADDR_POL, 1, "pol_rd");
    pol_mask = 4'b0001;
    check("pol_idle_pwm", W'(pwm_out), W'(4'b0001));
`else
    wr(ADDR_POL, 'hAA);
    rd(ADDR_POL, 0, "unmapped3");
`endif

    // Edge mode: PERIOD=9, PRESCALE=0, DUTY0=3, DUTY1=0, DUTY2=10
    wr(ADDR_PRESCALE, 0);
    wr(ADDR_PERIOD, 9);
    wr(ADDR_DUTY0 + 0, 3);
    wr(ADDR_DUTY0 + 1, 0);
    wr(ADDR_DUTY0 + 2, 10);
    wr(ADDR_DUTY0 + 3, 0);
    rd(ADDR_PERIOD, 9, "period_stg");
    repeat (3) step();
    check("rdata_hold", W'(reg_rdata), W'(9));
    wr(ADDR_CTRL, 1);
    check("edge_busy", W'(busy), W'(1));
    check("edge_state", W'(dbg_state), W'(RUN));
    wait_tick(ok);
    check("edge_tick_seen", W'(ok), W'(1));
    for (int k = 0; k < 20; k++) exp_q.push_back(edge_exp(k, 3, pol_mask));
    for (int k = 0; k < 20; k++) begin
      check($sformatf("edge_k%0d", k), W'({period_tick, pwm_out}), exp_q.pop_front());
      step();
    end

    // Duty write mid-period: staged immediately, active from the next period
    wait_tick(ok);
    check("shadow_tick_seen", W'(ok), W'(1));
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(edge_exp(k, (k > 10) ? 7 : 3, pol_mask));
      check($sformatf("shadow_k%0d", k), W'({period_tick, pwm_out}), exp_q.pop_front());
      if (k == 3) begin
        reg_we = 1'b1; reg_addr = ADDR_W'(ADDR_DUTY0); reg_wdata = 8'd7;
      end else if (k == 4) begin
        reg_we = 1'b0; reg_re = 1'b1; reg_addr = ADDR_W'(ADDR_DUTY0);
        rd_q.push_back(W'(7));
      end else if (k == 5) begin
        reg_re = 1'b0;
        check("duty_readback", W'(reg_rdata), rd_q.pop_front());
      end
      step();
    end

    // Stop, then centre mode: PERIOD=4, PRESCALE=1, DUTY0=2
    wr(ADDR_CTRL, 0);
    check("stop_pwm", W'(pwm_out), W'(pol_mask));
    check("stop_busy", W'(busy), '0);
    wr(ADDR_PERIOD, 4);
    wr(ADDR_PRESCALE, 1);
    wr(ADDR_DUTY0, 2);
    wr(ADDR_CTRL, 3);
    wait_tick(ok);
    check("centre_tick_seen", W'(ok), W'(1));
    for (int k = 0; k < 32; k++) exp_q.push_back(centre_exp(k, pol_mask));
    for (int k = 0; k < 32; k++) begin
      check($sformatf("centre_k%0d", k), W'({period_tick, pwm_out}), exp_q.pop_front());
      step();
    end

    // External start
    wr(ADDR_CTRL, 0);
    wr(ADDR_PERIOD, 9);
    wr(ADDR_PRESCALE, 0);
    wr(ADDR_DUTY0, 3);
    wr(ADDR_CTRL, 5);
    repeat (8) step();
    check("armed_busy", W'(busy), '0);
    check("armed_state", W'(dbg_state), W'(ARMED));
    start_ext = 1'b1;
    n = 0;
    while (!busy && n < 8) begin
      step();
      n++;
    end
    check("ext_start_latency", W'(busy && (n <= 4)), W'(1));
    start_ext = 1'b0;
    wait_tick(ok);
    check("ext_tick_seen", W'(ok), W'(1));
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) start_ext = 1'b1;
      if (k == 6) start_ext = 1'b0;
      step();
      if (period_tick && n == 0) n = k;
    end
    check("ext_second_pulse_period", W'(n), W'(10));
    check("ext_still_running", W'(dbg_state), W'(RUN));
    wr(ADDR_CTRL, 0);
    check("ext_stop_pwm", W'(pwm_out), W'(pol_mask));
    check("ext_stop_busy", W'(busy), '0);

    // Reset mid-run
    wr(ADDR_CTRL, 1);
    repeat (4) step();
    check("pre_rst_busy", W'(busy), W'(1));
    rst = 1'b1;
    step();
    check("midrun_rst_outs", W'({period_tick, busy, pwm_out}), '0);
    rst = 1'b0;
    pol_mask = '0;
    step();
    rd(ADDR_CTRL, 0, "post_rst_ctrl");
    rd(ADDR_PERIOD, 0, "post_rst_period");
    rd(ADDR_DUTY0, 0, "post_rst_duty0");
    rd(ADDR_POL, 0, "post_rst_pol");

    check("exp_q_empty", W'(exp_q.size()), '0);
    check("rd_q_empty", W'(rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
